// File: rtl/card_rom_arbiter_if.sv
// card_rom_arbiter_if
// Groups the requester-side and ROM-side signals of the card ROM arbiter.
//   req      per-requester read request (level)
//   addr     flattened requester addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt      one-hot grant, one cycle after the accepted request
//   rom_addr registered ROM address
//   rom_data ROM read data, ROM_LAT cycles after rom_addr
//   rdata    registered read data returned to the requesters
//   rvalid   one-hot owner of rdata
// The master modport is the environment (draw layers plus the ROM itself);
// the slave modport is the arbiter.
interface card_rom_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 12
) ();
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]       rom_addr;
  logic [DATA_W-1:0]       rom_data;
  logic [DATA_W-1:0]       rdata;
  logic [N_REQ-1:0]        rvalid;

  modport master (
    output req, addr, rom_data,
    input  gnt, rom_addr, rdata, rvalid
  );

  modport slave (
    input  req, addr, rom_data,
    output gnt, rom_addr, rdata, rvalid
  );
endinterface

// File: rtl/card_rom_arbiter.sv
// card_rom_arbiter
// Shares one synchronous card-image ROM port between N_REQ draw layers,
// one access per clock. Each read returns with a one-hot owner tag at a
// fixed latency: request in cycle n -> gnt/rom_addr in n+1 -> rdata/rvalid
// in n+2+ROM_LAT.
// Ports:
//   clk  pixel clock
//   rst  synchronous, active-high reset
//   bus  card_rom_arbiter_if.slave (req, addr, rom_data in; gnt, rom_addr,
//        rdata, rvalid out)
// Build option:
//   CARD_ARB_FIXED_PRIO_EN  fixed priority, lowest index wins, no last
//                           pointer. Default (undefined) is round-robin.
module card_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 12,
  parameter int ROM_LAT = 1
) (
  input logic              clk,
  input logic              rst,
  card_rom_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(N_REQ);

  logic             any_req;
  logic [IDX_W-1:0] win_idx;
  // tag_pipe[k] carries the grant tag k+1 cycles after gnt; the last stage
  // lines up with rom_data for that grant.
  logic [N_REQ-1:0] tag_pipe [ROM_LAT];

  assign any_req = |bus.req;

`ifdef CARD_ARB_FIXED_PRIO_EN
  function automatic logic [IDX_W-1:0] fixed_pick(input logic [N_REQ-1:0] r);
    logic [IDX_W-1:0] pick;
    pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (r[i]) pick = IDX_W'(i);
    end
    return pick;
  endfunction

  assign win_idx = fixed_pick(bus.req);
`else
  logic [IDX_W-1:0] last;

  // Search last+1, last+2, ... wrapping; last itself is checked last so a
  // lone requester still wins every cycle.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] l);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               j;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = int'(l) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && r[j]) begin
        found = 1'b1;
        pick  = IDX_W'(j);
      end
    end
    return pick;
  endfunction

  assign win_idx = rr_pick(bus.req, last);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.gnt      <= '0;
      bus.rom_addr <= '0;
      bus.rdata    <= '0;
      bus.rvalid   <= '0;
      for (int k = 0; k < ROM_LAT; k++) tag_pipe[k] <= '0;
`ifndef CARD_ARB_FIXED_PRIO_EN
      last <= IDX_W'(N_REQ - 1);
`endif
    end else begin
      if (any_req) begin
        bus.gnt      <= N_REQ'(1) << win_idx;
        bus.rom_addr <= bus.addr[win_idx*ADDR_W +: ADDR_W];
`ifndef CARD_ARB_FIXED_PRIO_EN
        last <= win_idx;
`endif
      end else begin
        // Idle: zero tag enters the pipe, rom_addr keeps its last value.
        bus.gnt <= '0;
      end

      tag_pipe[0] <= bus.gnt;
      for (int k = 1; k < ROM_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];

      bus.rvalid <= tag_pipe[ROM_LAT-1];
      if (|tag_pipe[ROM_LAT-1]) bus.rdata <= DATA_W'(bus.rom_data);
    end
  end

endmodule
